loop_cfg_seq: RTL and testbench
===============================

# loop_cfg_seq

Serial configuration sequencer for the loop-control brick: accepts a trim word one bit per clock, waits a programmable settle interval, then applies the word to the static control outputs that feed the loop-control tie/trim cells. Until a word has been applied, and after every reset, every control output is held at the tie-low level (all zeros). The block sits between the configuration bus and the generated loop-control bricks and is their only writer.

## Interface
Parameters:
- CFG_W, 8: trim word width in bits (≥2).
- SETTLE_CYC, 4: settle cycles between last bit and apply (≥0).

Ports:
- CELCLK  input  1  block clock, rising-edge.
- CELRST  input  1  reset, asynchronous, active-high.
- CELV  input  1  brick supply pin, no logic function.
- CELG  input  1  brick ground pin, no logic function.
- SUB  input  1  substrate pin, no logic function.
- cfg_start  input  1  start request, sampled each cycle.
- cfg_sval  input  1  serial bit valid.
- cfg_sdi  input  1  serial data, MSB first.
- cfg_busy  output  1  sequence in progress.
- cfg_done  output  1  one-cycle pulse: cfg_q just updated.
- cfg_err  output  1  sticky: cfg_start seen while busy.
- cfg_q  output  CFG_W  applied trim word.
- cfg_sdo  output  1  readback serial out (only with LOOP_CFG_READBACK_EN).

## Operation
- Reset (asynchronous, any state): state=IDLE; shadow, bit counter, settle counter, cfg_q cleared; cfg_busy, cfg_done, cfg_err, cfg_sdo = 0. Reset mid-sequence discards the partial word; cfg_q returns to all-zero (tie-low).
- IDLE: cfg_sval ignored. cfg_start=1 → SHIFT, bit counter=0, cfg_err cleared, cfg_busy=1.
- SHIFT: each cycle with cfg_sval=1: shadow <= {shadow[CFG_W-2:0], cfg_sdi}, counter+1. cfg_sval=0 stalls with no timeout. When the CFG_W-th bit is accepted → SETTLE with settle counter=SETTLE_CYC, or APPLY if SETTLE_CYC=0.
- SETTLE: decrement once per cycle; cfg_sval ignored. At 1 → APPLY.
- APPLY (one cycle): cfg_q <= shadow, cfg_done <= 1, cfg_busy <= 0, → IDLE.
- cfg_start while busy: ignored, sequence unaffected, cfg_err <= 1 until the next accepted start.
- cfg_start in the same cycle as APPLY: ignored and flags cfg_err.
- cfg_q changes only on an APPLY edge or on reset; it never shows partial words.
- Supply pins pass to no logic; they exist for brick netlisting.

## Timing
- cfg_start sampled at cycle 0 → cfg_busy=1 from cycle 1. First bit accepted no earlier than cycle 1.
- Last bit accepted in cycle N → SETTLE in cycles N+1..N+SETTLE_CYC → APPLY in cycle N+SETTLE_CYC+1 → cfg_q new value, cfg_done=1, and cfg_busy=0 in cycle N+SETTLE_CYC+2.
- cfg_done is high for exactly one cycle. A new start is accepted from the cycle cfg_done is high.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- LOOP_CFG_READBACK_EN defined: cfg_sdo port present and registered. On each accepted SHIFT beat, cfg_sdo <= shadow[CFG_W-1] (pre-shift), so a full load streams out the previously applied word MSB-first, one cycle after each accepted bit. cfg_sdo holds its value between beats; reset value is 0.
- Not defined: cfg_sdo port and its register absent. All other behaviour is identical.

## Test plan
- Reset: assert CELRST mid-SHIFT with CFG_W=8 → cfg_q=8'h00, busy/done/err=0 immediately, asynchronously; after release the block idles until cfg_start.
- Nominal load: CFG_W=8, SETTLE_CYC=4, start at cycle 0, bits of 8'hA5 on cycles 1–8 → cfg_q=8'hA5 and cfg_done=1 in cycle 14 only; busy high in cycles 1–13.
- Stalls: same word with cfg_sval=0 gaps of 3 cycles after bits 2 and 5 → cfg_q=8'hA5 six cycles later than nominal, in cycle 20; cfg_q stays 8'h00 before that.
- Collision: cfg_start pulsed at cycles 4 and 13 during nominal load → load completes as nominal, cfg_err=1 from cycle 5, cleared by the next start accepted in IDLE.
- Zero settle: SETTLE_CYC=0, load 8'h3C → cfg_done in cycle N+2; back-to-back second load 8'hC3 started on the cfg_done cycle → cfg_q=8'hC3 in cycle N'+2.
- Readback (macro on): load 8'hA5, then load 8'h0F → cfg_sdo sequence during the second load is 1,0,1,0,0,1,0,1; final cfg_q=8'h0F.

Source files
------------

// File: rtl/loop_cfg_if.sv
// loop_cfg_seq configuration bus: start, serial load and status.
// Readback pin cfg_sdo exists only with LOOP_CFG_READBACK_EN.
interface loop_cfg_if #(
   parameter int CFG_W = 8
);
   logic             cfg_start;
   logic             cfg_sval;
   logic             cfg_sdi;
   logic             cfg_busy;
   logic             cfg_done;
   logic             cfg_err;
   logic [CFG_W-1:0] cfg_q;
`ifdef LOOP_CFG_READBACK_EN
   logic             cfg_sdo;
`endif

   modport master (
      output cfg_start,
      output cfg_sval,
      output cfg_sdi,
      input  cfg_busy,
      input  cfg_done,
      input  cfg_err,
`ifdef LOOP_CFG_READBACK_EN
      input  cfg_sdo,
`endif
      input  cfg_q
   );

   modport slave (
      input  cfg_start,
      input  cfg_sval,
      input  cfg_sdi,
      output cfg_busy,
      output cfg_done,
      output cfg_err,
`ifdef LOOP_CFG_READBACK_EN
      output cfg_sdo,
`endif
      output cfg_q
   );
endinterface

// File: rtl/loop_cfg_seq.sv
// Serial trim-word loader: shift in, settle, apply to tie/trim controls.
// Optional readback stream on cfg_sdo with LOOP_CFG_READBACK_EN.
module loop_cfg_seq #(
   parameter int CFG_W      = 8,
   parameter int SETTLE_CYC = 4
) (
   input  logic        CELCLK,
   input  logic        CELRST,
   input  logic        CELV,
   input  logic        CELG,
   input  logic        SUB,
   loop_cfg_if.slave   bus
);

   localparam int BW = (CFG_W > 2) ? $clog2(CFG_W) : 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      SETTLE = 2'd2,
      APPLY  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [CFG_W-1:0] shadow;
   logic [CFG_W-1:0] q;
   logic [BW-1:0]    bit_cnt;
   logic [SW-1:0]    settle_cnt;
   logic             busy;
   logic             done;
   logic             err;

   logic             take_start;
   logic             beat;
   logic             last_beat;
   logic             do_apply;
   logic             flag_err;
   logic             settle_end;

   // Supply/substrate pins exist only for brick netlisting.
   wire unused_pins = &{CELV, CELG, SUB};

   assign last_beat  = beat && (bit_cnt == BW'(CFG_W - 1));
   assign settle_end = (settle_cnt == SW'(1));

   // State register.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state selection.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.cfg_start) state_nx = SHIFT;
         end
         SHIFT: begin
            if (last_beat) begin
               state_nx = (SETTLE_CYC == 0) ? APPLY : SETTLE;
            end
         end
         SETTLE: begin
            if (settle_end) state_nx = APPLY;
         end
         APPLY: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Per-state datapath controls; a start outside IDLE is a collision.
   always_comb begin
      take_start = 1'b0;
      beat       = 1'b0;
      do_apply   = 1'b0;
      flag_err   = 1'b0;
      unique case (state)
         IDLE: begin
            take_start = bus.cfg_start;
         end
         SHIFT: begin
            beat     = bus.cfg_sval;
            flag_err = bus.cfg_start;
         end
         SETTLE: begin
            flag_err = bus.cfg_start;
         end
         APPLY: begin
            do_apply = 1'b1;
            flag_err = bus.cfg_start;
         end
         default: ;
      endcase
   end

   // Shadow shift register and bit counter.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         shadow  <= '0;
         bit_cnt <= '0;
      end else begin
         if (take_start) begin
            bit_cnt <= '0;
         end else if (beat) begin
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (beat) begin
            shadow <= {shadow[CFG_W-2:0], bus.cfg_sdi};
         end
      end
   end

   // Settle down-counter, loaded on the last accepted bit.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         settle_cnt <= '0;
      end else if (last_beat) begin
         settle_cnt <= SW'(SETTLE_CYC);
      end else if (state == SETTLE) begin
         settle_cnt <= settle_cnt - SW'(1);
      end
   end

   // Applied word: only whole words, only on APPLY.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         q <= '0;
      end else if (do_apply) begin
         q <= shadow;
      end
   end

   // Status flags: busy span, done pulse, sticky collision error.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         busy <= 1'b0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         done <= do_apply;
         if (take_start) begin
            busy <= 1'b1;
         end else if (do_apply) begin
            busy <= 1'b0;
         end
         if (take_start) begin
            err <= 1'b0;
         end else if (flag_err) begin
            err <= 1'b1;
         end
      end
   end

`ifdef LOOP_CFG_READBACK_EN
   logic sdo;

   // Readback: the bit falling out of the shadow on each beat.
   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         sdo <= 1'b0;
      end else if (beat) begin
         sdo <= shadow[CFG_W-1];
      end
   end

   assign bus.cfg_sdo = sdo;
`endif

   assign bus.cfg_busy = busy;
   assign bus.cfg_done = done;
   assign bus.cfg_err  = err;
   assign bus.cfg_q    = q;

endmodule

// File: tb/tb_loop_cfg_seq.sv
// Directed bench for loop_cfg_seq (settle 4 and settle 0 instances).
// Readback checks compile in with LOOP_CFG_READBACK_EN.
module tb_loop_cfg_seq;

   logic       clk;
   logic       rst;
   logic       sel;
   logic       d_start;
   logic       d_sval;
   logic       d_sdi;
   int         checks;
   int         failures;

   logic       o_busy;
   logic       o_done;
   logic       o_err;
   logic [7:0] o_q;

`ifdef LOOP_CFG_READBACK_EN
   logic       sdo_exp;
   logic [7:0] a_sh;
`endif

   loop_cfg_if #(.CFG_W(8)) ifa ();
   loop_cfg_if #(.CFG_W(8)) ifz ();

   loop_cfg_seq #(.CFG_W(8), .SETTLE_CYC(4)) dut_a (
      .CELCLK (clk),
      .CELRST (rst),
      .CELV   (1'b1),
      .CELG   (1'b0),
      .SUB    (1'b0),
      .bus    (ifa)
   );

   loop_cfg_seq #(.CFG_W(8), .SETTLE_CYC(0)) dut_z (
      .CELCLK (clk),
      .CELRST (rst),
      .CELV   (1'b1),
      .CELG   (1'b0),
      .SUB    (1'b0),
      .bus    (ifz)
   );

   assign ifa.cfg_start = !sel && d_start;
   assign ifa.cfg_sval  = !sel && d_sval;
   assign ifa.cfg_sdi   = d_sdi;
   assign ifz.cfg_start = sel && d_start;
   assign ifz.cfg_sval  = sel && d_sval;
   assign ifz.cfg_sdi   = d_sdi;

   assign o_busy = sel ? ifz.cfg_busy : ifa.cfg_busy;
   assign o_done = sel ? ifz.cfg_done : ifa.cfg_done;
   assign o_err  = sel ? ifz.cfg_err  : ifa.cfg_err;
   assign o_q    = sel ? ifz.cfg_q    : ifa.cfg_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int acc_cyc(input int b, input int gap);
      return 1 + b + ((b >= 2) ? gap : 0) + ((b >= 5) ? gap : 0);
   endfunction

   // Cycle 0 is the current cycle; start is driven in it.
   task automatic run_load(input logic s, input logic [7:0] w,
                           input logic [7:0] prev, input int gap,
                           input bit coll, input int settle);
      int  dcyc;
      int  b;
      bit  acc;
      dcyc = 8 + 2 * gap + settle + 2;
      b    = 0;
      sel  = s;
      for (int c = 0; c <= dcyc; c++) begin
         if (c >= 1) begin
            chk("busy", {31'd0, o_busy}, {31'd0, c < dcyc});
            chk("done", {31'd0, o_done}, {31'd0, c == dcyc});
            chk("q", {24'd0, o_q}, {24'd0, (c == dcyc) ? w : prev});
            chk("err", {31'd0, o_err}, {31'd0, coll && c >= 5});
`ifdef LOOP_CFG_READBACK_EN
            if (!s) chk("sdo", {31'd0, ifa.cfg_sdo}, {31'd0, sdo_exp});
`endif
         end
         if (c == dcyc) break;
         d_start = (c == 0) || (coll && (c == 4 || c == 13));
         acc     = (c >= 1) && (b < 8) && (c == acc_cyc(b, gap));
         if (acc) begin
            d_sval = 1'b1;
            d_sdi  = w[7-b];
`ifdef LOOP_CFG_READBACK_EN
            if (!s) begin
               sdo_exp = a_sh[7];
               a_sh    = {a_sh[6:0], w[7-b]};
            end
`endif
            b++;
         end else begin
            d_sval = (b == 8);
            d_sdi  = 1'($urandom);
         end
         step();
      end
      d_start = 1'b0;
      d_sval  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      sel      = 1'b0;
      d_start  = 1'b0;
      d_sval   = 1'b0;
      d_sdi    = 1'b0;
`ifdef LOOP_CFG_READBACK_EN
      sdo_exp  = 1'b0;
      a_sh     = 8'h00;
`endif
      rst = 1'b1;
      step();
      step();
      chk("rst_q_a", {24'd0, ifa.cfg_q}, 32'h0);
      chk("rst_busy_a", {31'd0, ifa.cfg_busy}, 32'h0);
      chk("rst_q_z", {24'd0, ifz.cfg_q}, 32'h0);
      chk("rst_done_z", {31'd0, ifz.cfg_done}, 32'h0);
      rst = 1'b0;
      step();

      // Nominal: A5, done in cycle 14.
      run_load(1'b0, 8'hA5, 8'h00, 0, 1'b0, 4);
      // Collisions at cycles 4 and 13 during a 5A load.
      run_load(1'b0, 8'h5A, 8'hA5, 0, 1'b1, 4);
      // Two 3-cycle stalls: done in cycle 20.
      run_load(1'b0, 8'hA5, 8'h5A, 3, 1'b0, 4);
      // 0F after A5: readback streams A5.
      run_load(1'b0, 8'h0F, 8'hA5, 0, 1'b0, 4);
      step();
      chk("done_drop", {31'd0, o_done}, 32'h0);
      chk("q_hold", {24'd0, o_q}, 32'h0F);

      // Async reset mid-SHIFT with err set.
      d_start = 1'b1;
      step();
      d_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_sval = 1'b1;
         d_sdi  = 1'b1;
         step();
      end
      d_sval  = 1'b0;
      d_start = 1'b1;
      step();
      d_start = 1'b0;
      chk("pre_err", {31'd0, o_err}, 32'h1);
      chk("pre_busy", {31'd0, o_busy}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_q", {24'd0, o_q}, 32'h0);
      chk("arst_busy", {31'd0, o_busy}, 32'h0);
      chk("arst_done", {31'd0, o_done}, 32'h0);
      chk("arst_err", {31'd0, o_err}, 32'h0);
`ifdef LOOP_CFG_READBACK_EN
      chk("arst_sdo", {31'd0, ifa.cfg_sdo}, 32'h0);
      sdo_exp = 1'b0;
      a_sh    = 8'h00;
`endif
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_sval = 1'b1;
         d_sdi  = 1'($urandom);
         step();
         chk("idle_busy", {31'd0, o_busy}, 32'h0);
         chk("idle_q", {24'd0, o_q}, 32'h0);
      end
      d_sval = 1'b0;

      // Zero settle, back-to-back from the done cycle.
      run_load(1'b1, 8'h3C, 8'h00, 0, 1'b0, 0);
      run_load(1'b1, 8'hC3, 8'h3C, 0, 1'b0, 0);
      step();
      chk("z_done_drop", {31'd0, o_done}, 32'h0);
      chk("z_q_hold", {24'd0, o_q}, 32'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
